// File: rtl/usb_enc_pkg.sv
// usb_enc_pkg: shared state, line-state encodings and helpers for the USB NRZI TX encoder.
// USB_NRZI_LOW_SPEED_EN selects low-speed J/K polarity.
package usb_enc_pkg;
    typedef logic [1:0] state_t;
    localparam state_t IDLE    = 2'd0;
    localparam state_t DATA    = 2'd1;
    localparam state_t EOP_SE0 = 2'd2;
    localparam state_t EOP_J   = 2'd3;

    // {d_plus, d_minus}
    typedef logic [1:0] line_t;
`ifdef USB_NRZI_LOW_SPEED_EN
    localparam line_t LINE_J = 2'b01;
`else
    localparam line_t LINE_J = 2'b10;
`endif
    localparam line_t LINE_K   = ~LINE_J;
    localparam line_t LINE_SE0 = 2'b00;

    function automatic int max(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/usb_enc_bit_timer.sv
// usb_enc_bit_timer: free-running wrapping counter that flags the last clk of each USB bit time.
module usb_enc_bit_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    output logic bit_tick
);
    localparam int W = $clog2(CLKS_PER_BIT);
    logic [W-1:0] cnt;
    assign bit_tick = cnt == W'(CLKS_PER_BIT - 1);
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) cnt <= '0;
        else cnt <= bit_tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/usb_nrzi_tx_encoder.sv
// usb_nrzi_tx_encoder: NRZI encoder with bit stuffing and configurable SE0+J end-of-packet.
// Define USB_NRZI_LOW_SPEED_EN for low-speed J/K polarity.
module usb_nrzi_tx_encoder
    import usb_enc_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_LEN    = 6,
    parameter int EOP_SE0_BITS = 2,
    parameter int EOP_J_BITS   = 1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic tx_valid,
    input  logic tx_bit,
    output logic tx_ready,
    input  logic eop_req,
    output logic d_plus,
    output logic d_minus,
    output logic busy,
    output logic eop_done,
    output logic underrun
);
    localparam int OW = $clog2(STUFF_LEN + 1);
    localparam int PW = $clog2(max(EOP_SE0_BITS, EOP_J_BITS) + 1);

    logic bit_tick, stuff_due, und_nxt, done_nxt;
    state_t state, state_nxt;
    line_t lvl, lvl_nxt, line_nxt;
    logic [OW-1:0] ones_cnt, ones_nxt;
    logic [PW-1:0] phase, phase_nxt;

    usb_enc_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk(clk), .n_rst(n_rst), .bit_tick(bit_tick)
    );

    assign stuff_due = ones_cnt == OW'(STUFF_LEN);
    assign tx_ready  = bit_tick && (state == IDLE || (state == DATA && !stuff_due));
    assign busy      = state != IDLE;

    always_comb begin
        state_nxt = state;
        lvl_nxt   = lvl;
        ones_nxt  = ones_cnt;
        phase_nxt = phase + 1'b1;
        und_nxt   = 1'b0;
        done_nxt  = 1'b0;
        if (bit_tick)
            case (state)
                IDLE: if (tx_valid) begin
                    state_nxt = DATA;
                    lvl_nxt   = tx_bit ? lvl : ~lvl;
                    ones_nxt  = tx_bit ? ones_cnt + 1'b1 : '0;
                end
                DATA: if (stuff_due) begin
                    lvl_nxt  = ~lvl;
                    ones_nxt = '0;
                end else if (tx_valid) begin
                    lvl_nxt  = tx_bit ? lvl : ~lvl;
                    ones_nxt = tx_bit ? ones_cnt + 1'b1 : '0;
                end else begin
                    // without eop_req this is an abort, still terminated by a normal EOP
                    state_nxt = EOP_SE0;
                    ones_nxt  = '0;
                    und_nxt   = !eop_req;
                end
                EOP_SE0: if (phase == PW'(EOP_SE0_BITS - 1)) state_nxt = EOP_J;
                default: if (phase == PW'(EOP_J_BITS - 1)) begin
                    state_nxt = IDLE;
                    lvl_nxt   = LINE_J;
                    done_nxt  = 1'b1;
                end
            endcase
        line_nxt = state_nxt == EOP_SE0 ? LINE_SE0 : state_nxt == DATA ? lvl_nxt : LINE_J;
    end

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            state              <= IDLE;
            lvl                <= LINE_J;
            ones_cnt           <= '0;
            phase              <= '0;
            {d_plus, d_minus}  <= LINE_J;
            eop_done           <= 1'b0;
            underrun           <= 1'b0;
        end else begin
            state              <= state_nxt;
            lvl                <= lvl_nxt;
            ones_cnt           <= ones_nxt;
            phase              <= state_nxt != state ? '0 : (bit_tick ? phase_nxt : phase);
            {d_plus, d_minus}  <= line_nxt;
            eop_done           <= done_nxt;
            underrun           <= und_nxt;
        end
endmodule

// File: tb/tb_usb_nrzi_tx_encoder.sv
// tb_usb_nrzi_tx_encoder: scoreboard bench over two encoder configurations sharing one bit clock.
module tb_usb_nrzi_tx_encoder;
    localparam int CPB = 4;
`ifdef USB_NRZI_LOW_SPEED_EN
    localparam logic [1:0] J = 2'b01;
`else
    localparam logic [1:0] J = 2'b10;
`endif
    localparam logic [1:0] K = ~J;
    localparam logic [1:0] S = 2'b00;

    logic clk = 1'b0, n_rst = 1'b0, sel = 1'b0;
    logic a_v = 1'b0, a_b = 1'b0, a_e = 1'b0, b_v = 1'b0, b_b = 1'b0, b_e = 1'b0;
    logic a_rdy, a_dp, a_dm, a_busy, a_done, a_und;
    logic b_rdy, b_dp, b_dm, b_busy, b_done, b_und;
    logic rdy, dp, dm, bsy, dn, und;

    always #5 clk = ~clk;

    usb_nrzi_tx_encoder #(.CLKS_PER_BIT(CPB)) dut_a (
        .clk(clk), .n_rst(n_rst), .tx_valid(a_v), .tx_bit(a_b), .tx_ready(a_rdy),
        .eop_req(a_e), .d_plus(a_dp), .d_minus(a_dm), .busy(a_busy),
        .eop_done(a_done), .underrun(a_und)
    );
    usb_nrzi_tx_encoder #(.CLKS_PER_BIT(CPB), .STUFF_LEN(3), .EOP_SE0_BITS(3), .EOP_J_BITS(2)) dut_b (
        .clk(clk), .n_rst(n_rst), .tx_valid(b_v), .tx_bit(b_b), .tx_ready(b_rdy),
        .eop_req(b_e), .d_plus(b_dp), .d_minus(b_dm), .busy(b_busy),
        .eop_done(b_done), .underrun(b_und)
    );

    assign {rdy, dp, dm, bsy, dn, und} = sel ? {b_rdy, b_dp, b_dm, b_busy, b_done, b_und}
                                             : {a_rdy, a_dp, a_dm, a_busy, a_done, a_und};

    typedef struct packed {logic [1:0] ln; logic rdy, bsy, und, dn;} exp_t;
    exp_t sb[$];
    int n_cmp = 0, n_bad = 0, n_slot = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (slot %0d): got %0h expected %0h", tag, n_slot, got, exp);
        end
    endtask

    // one bit time: drive at the negedge after a tick edge, check tx_ready in the tick cycle, check outputs after the edge
    task automatic slot(input logic s, v, bt, e, input logic [1:0] ln, input logic r, b, u, d);
        exp_t x;
        sel = s;
        if (s) {b_v, b_b, b_e} = {v, bt, e};
        else   {a_v, a_b, a_e} = {v, bt, e};
        sb.push_back('{ln, r, b, u, d});
        repeat (CPB - 1) @(posedge clk);
        @(negedge clk);
        check("tx_ready", 32'(rdy), 32'(sb[0].rdy));
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("line", 32'({dp, dm}), 32'(x.ln));
        check("busy", 32'(bsy), 32'(x.bsy));
        check("underrun", 32'(und), 32'(x.und));
        check("eop_done", 32'(dn), 32'(x.dn));
        n_slot++;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_line", 32'({a_dp, a_dm}), 32'(J));
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_ready", 32'(a_rdy), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_und", 32'(a_und), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        // 0,0,1,0 then EOP
        slot(0, 1, 0, 0, K, 1, 1, 0, 0);
        slot(0, 1, 0, 0, J, 1, 1, 0, 0);
        slot(0, 1, 1, 0, J, 1, 1, 0, 0);
        slot(0, 1, 0, 0, K, 1, 1, 0, 0);
        slot(0, 0, 0, 1, S, 1, 1, 0, 0);
        slot(0, 0, 0, 1, S, 0, 1, 0, 0);
        slot(0, 0, 0, 0, J, 0, 1, 0, 0);
        slot(0, 0, 0, 0, J, 0, 0, 0, 1);
        slot(0, 0, 0, 0, J, 1, 0, 0, 0);
        // eight 1s with a stuffed 0 after the sixth
        for (int i = 0; i < 6; i++) slot(0, 1, 1, 0, J, 1, 1, 0, 0);
        slot(0, 1, 1, 0, K, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) slot(0, 1, 1, 0, K, 1, 1, 0, 0);
        slot(0, 0, 0, 1, S, 1, 1, 0, 0);
        slot(0, 0, 0, 0, S, 0, 1, 0, 0);
        slot(0, 0, 0, 0, J, 0, 1, 0, 0);
        slot(0, 0, 0, 0, J, 0, 0, 0, 1);
        // stuff bit due with eop_req already high goes out before SE0
        for (int i = 0; i < 5; i++) slot(0, 1, 1, 0, J, 1, 1, 0, 0);
        slot(0, 1, 1, 1, J, 1, 1, 0, 0);
        slot(0, 0, 0, 1, K, 0, 1, 0, 0);
        slot(0, 0, 0, 1, S, 1, 1, 0, 0);
        slot(0, 0, 0, 0, S, 0, 1, 0, 0);
        slot(0, 0, 0, 0, J, 0, 1, 0, 0);
        slot(0, 0, 0, 0, J, 0, 0, 0, 1);
        // underrun abort
        slot(0, 1, 0, 0, K, 1, 1, 0, 0);
        slot(0, 0, 0, 0, S, 1, 1, 1, 0);
        slot(0, 0, 0, 0, S, 0, 1, 0, 0);
        slot(0, 0, 0, 0, J, 0, 1, 0, 0);
        slot(0, 0, 0, 0, J, 0, 0, 0, 1);
        // STUFF_LEN=3, SE0 3 bits, J 2 bits
        for (int i = 0; i < 3; i++) slot(1, 1, 1, 0, J, 1, 1, 0, 0);
        slot(1, 1, 1, 0, K, 0, 1, 0, 0);
        slot(1, 1, 1, 0, K, 1, 1, 0, 0);
        slot(1, 1, 0, 0, J, 1, 1, 0, 0);
        slot(1, 0, 0, 1, S, 1, 1, 0, 0);
        for (int i = 0; i < 2; i++) slot(1, 0, 0, 0, S, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) slot(1, 0, 0, 0, J, 0, 1, 0, 0);
        slot(1, 0, 0, 0, J, 0, 0, 0, 1);
        // asynchronous reset during SE0
        slot(0, 1, 0, 0, K, 1, 1, 0, 0);
        slot(0, 0, 0, 1, S, 1, 1, 0, 0);
        a_e = 1'b0;
        @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("arst_line", 32'({a_dp, a_dm}), 32'(J));
        check("arst_busy", 32'(a_busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("arst_no_done", 32'(a_done), 32'd0);
        end
        @(negedge clk);
        n_rst = 1'b1;
        slot(0, 0, 0, 0, J, 1, 0, 0, 0);
        slot(0, 0, 0, 0, J, 1, 0, 0, 0);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
